// File: rtl/int_ack_responder.sv
// int_ack_responder
//   Interrupt request/acknowledge responder on the CPU data bus. A level
//   interrupt on interrupt_in moves the block from IDLE to PENDING and raises
//   hwint (if enabled). Software acknowledges by writing the ACK register. The
//   block then waits in ACK_WAIT until the level drops, so a held level never
//   re-triggers. Accepted and spurious acknowledges are counted.
//
// Register map (word aligned, m_addr[1:0] ignored):
//   0x7F20 ACK   : write = acknowledge, read = {30'b0, state}
//   0x7F24 COUNT : accepted acknowledge count (byte writable)
//   0x7F28 SPUR  : spurious acknowledge count (byte writable)
//   0x7F2C EN    : bit0 = interrupt enable
//
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   interrupt_in : external level interrupt request
//   m_addr       : bus byte address
//   m_wdata      : bus write data
//   m_byteen     : per-byte write enables, any bit set = write
//   m_rdata      : combinational read data, 0 when not decoded
//   hwint        : registered interrupt request to CP0
//   hit          : combinational address decode hit
module int_ack_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt_in,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_byteen,
  output logic [31:0] m_rdata,
  output logic        hwint,
  output logic        hit
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StAckWait = 2'd2,
    StBad     = 2'd3
  } state_e;

  localparam logic [29:0] WordAck   = 30'h1FC8;  // 0x7F20
  localparam logic [29:0] WordCount = 30'h1FC9;  // 0x7F24
  localparam logic [29:0] WordSpur  = 30'h1FCA;  // 0x7F28
  localparam logic [29:0] WordEn    = 30'h1FCB;  // 0x7F2C

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_count;
  logic [31:0] r_spur;
  logic        r_en;
  logic        r_hwint;

  logic        w_sel_ack;
  logic        w_sel_count;
  logic        w_sel_spur;
  logic        w_sel_en;
  logic        w_wr;
  logic        w_ack_ok;
  logic        w_ack_spur;
  logic [31:0] w_count_inc;
  logic [31:0] w_spur_inc;
  logic [31:0] w_count_next;
  logic [31:0] w_spur_next;
  logic        w_en_next;
  logic        w_unused_addr;

  assign w_unused_addr = ^m_addr[1:0];

  assign w_sel_ack   = (m_addr[31:2] == WordAck);
  assign w_sel_count = (m_addr[31:2] == WordCount);
  assign w_sel_spur  = (m_addr[31:2] == WordSpur);
  assign w_sel_en    = (m_addr[31:2] == WordEn);
  assign hit         = w_sel_ack | w_sel_count | w_sel_spur | w_sel_en;
  assign w_wr        = |m_byteen;

  // Only an ACK write in PENDING is accepted; any other ACK write is spurious.
  assign w_ack_ok   = w_sel_ack & w_wr & (r_state == StPending);
  assign w_ack_spur = w_sel_ack & w_wr & (r_state != StPending);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (interrupt_in) w_state_next = StPending;
      StPending: if (w_ack_ok) w_state_next = StAckWait;
      StAckWait: if (!interrupt_in) w_state_next = StIdle;
      StBad:     w_state_next = StIdle;
    endcase
  end

  // Counters: written bytes win, unwritten bytes take the incremented value.
  assign w_count_inc = r_count + {31'b0, w_ack_ok};
  assign w_spur_inc  = r_spur + {31'b0, w_ack_spur};

  always_comb begin
    w_count_next = w_count_inc;
    w_spur_next  = w_spur_inc;
    for (int b = 0; b < 4; b++) begin
      if (w_sel_count && m_byteen[b]) w_count_next[8*b +: 8] = m_wdata[8*b +: 8];
      if (w_sel_spur && m_byteen[b])  w_spur_next[8*b +: 8]  = m_wdata[8*b +: 8];
    end
  end

  assign w_en_next = (w_sel_en && m_byteen[0]) ? m_wdata[0] : r_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_count <= 32'h0;
      r_spur  <= 32'h0;
      r_en    <= 1'b1;
      r_hwint <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_spur  <= w_spur_next;
      r_en    <= w_en_next;
      // Uses the enable as it stands before this edge's write.
      r_hwint <= (w_state_next == StPending) & r_en;
    end
  end

  assign hwint = r_hwint;

  // Reads see register values before this edge's update.
  always_comb begin
    m_rdata = 32'h0;
    if (w_sel_ack)        m_rdata = {30'b0, r_state};
    else if (w_sel_count) m_rdata = r_count;
    else if (w_sel_spur)  m_rdata = r_spur;
    else if (w_sel_en)    m_rdata = {31'b0, r_en};
  end

endmodule

// File: tb/tb_int_ack_responder.sv
module tb_int_ack_responder;

  localparam logic [31:0] AAck   = 32'h0000_7F20;
  localparam logic [31:0] ACount = 32'h0000_7F24;
  localparam logic [31:0] ASpur  = 32'h0000_7F28;
  localparam logic [31:0] AEn    = 32'h0000_7F2C;

  logic        clk;
  logic        reset;
  logic        interrupt_in;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic [31:0] m_rdata;
  logic        hwint;
  logic        hit;

  logic        rd_strobe;

  int errors;
  int checks;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        hwint;
    logic        hw_chk;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];

  int_ack_responder dut (
    .clk          (clk),
    .reset        (reset),
    .interrupt_in (interrupt_in),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_byteen     (m_byteen),
    .m_rdata      (m_rdata),
    .hwint        (hwint),
    .hit          (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every read presented on the bus is compared to the queue head.
  always @(negedge clk) begin
    if (rd_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: read with empty scoreboard, rdata=%h", m_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (m_rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h want %h", e.name, m_rdata, e.rdata);
        end
        checks++;
        if (hit !== e.hit) begin
          errors++;
          $display("FAIL %s hit: got %b want %b", e.name, hit, e.hit);
        end
        if (e.hw_chk) begin
          checks++;
          if (hwint !== e.hwint) begin
            errors++;
            $display("FAIL %s hwint: got %b want %b", e.name, hwint, e.hwint);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    m_byteen  = 4'h0;
    rd_strobe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_addr   = a;
    m_wdata  = d;
    m_byteen = be;
    cycle();
    bus_idle();
  endtask

  task automatic rd_full(input logic [31:0] a, input logic [31:0] e, input logic eh,
                         input logic hw_chk, input logic ehit, input string nm);
    exp_t x;
    x.name   = nm;
    x.rdata  = e;
    x.hwint  = eh;
    x.hw_chk = hw_chk;
    x.hit    = ehit;
    exp_q.push_back(x);
    m_addr    = a;
    m_byteen  = 4'h0;
    rd_strobe = 1'b1;
    cycle();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic eh, input string nm);
    rd_full(a, e, eh, 1'b1, 1'b1, nm);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    interrupt_in = 1'b0;
    bus_idle();
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state
    rd(AAck,   32'h0, 1'b0, "rst_state");
    rd(ACount, 32'h0, 1'b0, "rst_count");
    rd(ASpur,  32'h0, 1'b0, "rst_spur");
    rd(AEn,    32'h1, 1'b0, "rst_en");

    // Basic handshake
    interrupt_in = 1'b1;
    cycle();
    rd(AAck, 32'h1, 1'b1, "hs_pending");
    cycle();
    wr(AAck, 32'h0, 4'hF);
    rd(AAck, 32'h2, 1'b0, "hs_ackwait");
    interrupt_in = 1'b0;
    cycle();
    rd(AAck,   32'h0, 1'b0, "hs_idle");
    rd(ACount, 32'h1, 1'b0, "hs_count");
    rd(ASpur,  32'h0, 1'b0, "hs_spur");

    // Held level: ack while interrupt_in stays high, plus a spurious ack in ACK_WAIT
    interrupt_in = 1'b1;
    cycle();
    wr(AAck, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) rd(AAck, 32'h2, 1'b0, "held_ackwait");
    wr(AAck, 32'h0, 4'h1);
    rd(ASpur,  32'h1, 1'b0, "held_spur");
    rd(ACount, 32'h2, 1'b0, "held_count");
    interrupt_in = 1'b0;
    rd(AAck, 32'h2, 1'b0, "held_before_drop");
    rd(AAck, 32'h0, 1'b0, "held_idle");

    // Spurious ack in IDLE from a fresh reset
    do_reset();
    wr(AAck, 32'h0, 4'hF);
    rd(ASpur,  32'h1, 1'b0, "spur_spur");
    rd(ACount, 32'h0, 1'b0, "spur_count");
    rd(AAck,   32'h0, 1'b0, "spur_state");

    // Mask
    wr(AEn, 32'h0, 4'h1);
    rd(AEn, 32'h0, 1'b0, "mask_en0");
    wr(AEn, 32'h1, 4'hE);
    rd(AEn, 32'h0, 1'b0, "mask_en_be");
    interrupt_in = 1'b1;
    cycle();
    rd(AAck, 32'h1, 1'b0, "mask_pending");
    wr(AEn, 32'h1, 4'h1);
    rd_full(AAck, 32'h1, 1'b0, 1'b0, 1'b1, "mask_en_written");
    rd(AAck, 32'h1, 1'b1, "mask_unmasked");
    wr(AAck, 32'h0, 4'hF);
    interrupt_in = 1'b0;
    cycle();
    rd(ACount, 32'h1, 1'b0, "mask_count");

    // Wrap and byte writes
    wr(ACount, 32'hFFFF_FFFF, 4'hF);
    rd(ACount, 32'hFFFF_FFFF, 1'b0, "wrap_preset");
    interrupt_in = 1'b1;
    cycle();
    wr(AAck, 32'h0, 4'hF);
    interrupt_in = 1'b0;
    cycle();
    rd(ACount, 32'h0, 1'b0, "wrap_zero");
    wr(ACount, 32'h0000_00AB, 4'b0001);
    rd(ACount, 32'h0000_00AB, 1'b0, "byte0");
    wr(ACount, 32'hFFFF_12FF, 4'b0010);
    rd(ACount, 32'h0000_12AB, 1'b0, "byte1");
    wr(ASpur, 32'hDEAD_0000, 4'b1100);
    rd(ASpur, 32'hDEAD_0001, 1'b0, "spur_bytes");

    // Out-of-range addresses
    wr(32'h0000_7F30, 32'h5555_5555, 4'hF);
    wr(32'h0000_7F1C, 32'h5555_5555, 4'hF);
    wr(32'h1000_7F24, 32'h5555_5555, 4'hF);
    rd_full(32'h0000_7F30, 32'h0, 1'b0, 1'b1, 1'b0, "oor_7f30");
    rd_full(32'h1000_7F24, 32'h0, 1'b0, 1'b1, 1'b0, "oor_alias");
    rd(ACount, 32'h0000_12AB, 1'b0, "oor_count");
    rd(32'h0000_7F27, 32'h0000_12AB, 1'b0, "low_bits_ignored");

    // Reset mid-PENDING with a simultaneous ack write
    interrupt_in = 1'b1;
    cycle();
    rd(AAck, 32'h1, 1'b1, "rstp_pending");
    reset    = 1'b1;
    m_addr   = AAck;
    m_byteen = 4'hF;
    cycle();
    reset = 1'b0;
    bus_idle();
    rd(AAck,   32'h0, 1'b0, "rstp_idle");
    rd(AAck,   32'h1, 1'b1, "rstp_repend");
    rd(ACount, 32'h0, 1'b1, "rstp_count");
    rd(ASpur,  32'h0, 1'b1, "rstp_spur");

    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_ack_responder.md
INT_ACK_RESPONDER -- requirements
Module: int_ack_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port interrupt_in, input, 1 bit: external level interrupt request, may change on the falling edge of clk.
REQ-004 SHALL have port m_addr, input, 32 bits: CPU data-bus byte address; bits [1:0] ignored for decode.
REQ-005 SHALL have port m_wdata, input, 32 bits: CPU write data.
REQ-006 SHALL have port m_byteen, input, 4 bits: per-byte write enables; any bit set means a write.
REQ-007 SHALL have port m_rdata, output, 32 bits: combinational read data for the decoded register, 0 when no register is decoded.
REQ-008 SHALL have port hwint, output, 1 bit: registered interrupt request to CP0.
REQ-009 SHALL have port hit, output, 1 bit: combinational, 1 when m_addr[31:2] decodes to any register below.

Function
REQ-010 SHALL decode four word registers (byte addresses):
- 0x7F20 ACK: any write acknowledges; a read returns {30'b0, state[1:0]}.
- 0x7F24 COUNT: 32-bit count of accepted acknowledges.
- 0x7F28 SPUR: 32-bit count of spurious acknowledges.
- 0x7F2C EN: bit0 is the interrupt enable; bits 31:1 read as 0.
REQ-011 SHALL implement state encodings IDLE=0, PENDING=1, ACK_WAIT=2; encoding 3 SHALL be unreachable and SHALL return to IDLE on the next clock edge.
REQ-012 In IDLE, when interrupt_in=1 at a rising edge, the block SHALL go to PENDING.
REQ-013 In PENDING, a write to ACK SHALL move the block to ACK_WAIT and increment COUNT by 1 on the same edge.
REQ-014 In ACK_WAIT, when interrupt_in=0 at a rising edge, the block SHALL go to IDLE; while interrupt_in stays 1 the block SHALL remain in ACK_WAIT, so a held level never re-triggers.
REQ-015 A write to ACK while in IDLE or ACK_WAIT SHALL increment SPUR by 1 and SHALL leave the state unchanged.
REQ-016 hwint SHALL be registered and equal (next_state==PENDING) & EN[0], so that:
- hwint rises on the first rising edge at which interrupt_in=1 is sampled in IDLE (latency 1 edge).
- hwint falls on the same edge that accepts the ACK write.
REQ-017 EN=0 SHALL mask hwint only; state transitions SHALL continue; setting EN=1 while in PENDING SHALL raise hwint on the next edge.
REQ-018 Writes to COUNT, SPUR and EN SHALL honour m_byteen per byte; only bit0 of EN is stored.
REQ-019 COUNT and SPUR SHALL wrap from 0xFFFFFFFF to 0x00000000 without saturation.
REQ-020 If a write to COUNT coincides with an accepted ACK, the written bytes SHALL take effect and the unwritten bytes SHALL take the incremented value.
REQ-021 Writes to m_addr outside 0x7F20-0x7F2F SHALL have no effect; hit=0 and m_rdata=0 for them.
REQ-022 Reads SHALL return register values before the current edge's update (no write-through bypass).

Reset
REQ-023 On reset=1 at a rising edge:
- state=IDLE, hwint=0, COUNT=0, SPUR=0, EN[0]=1.
- interrupt_in and bus writes in that cycle SHALL be ignored.
REQ-024 Reset asserted mid-operation (PENDING or ACK_WAIT) SHALL take effect at the next edge and SHALL override any simultaneous ACK write.
REQ-025 After reset deasserts, a still-high interrupt_in SHALL be taken as a new request (IDLE->PENDING).

Verification
REQ-026 Basic handshake:
- Stimulus: interrupt_in 0->1, then 3 cycles later a sw to 0x7F20 with byteen=4'b1111, then interrupt_in 0.
- Response: hwint=1 one edge after the sample, hwint=0 on the ack edge, COUNT=1, SPUR=0, state returns to IDLE.
REQ-027 Held level:
- Stimulus: ack while interrupt_in stays 1 for 10 cycles.
- Response: state=2, hwint=0 throughout; goes to IDLE one edge after interrupt_in=0.
REQ-028 Spurious ack:
- Stimulus: write 0x7F20 in IDLE.
- Response: SPUR=1, COUNT=0, state=0, hwint=0.
REQ-029 Mask:
- Stimulus: write EN=0, raise interrupt_in.
- Response: read 0x7F20 returns 1, hwint=0; write EN=1 gives hwint=1 on the next edge.
REQ-030 Wrap and byte write:
- Stimulus: write COUNT=0xFFFFFFFF, then ack.
- Response: COUNT=0x00000000.
- Stimulus: write COUNT with byteen=4'b0001 and wdata=0x000000AB.
- Response: COUNT=0x000000AB.
REQ-031 Reset mid-PENDING:
- Stimulus: assert reset for one edge with interrupt_in=1 and a simultaneous ack write.
- Response: COUNT=0, hwint=0, state=0; state goes to PENDING on the next edge.
